// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core types: mul/div op codes, mul/div sequencer states and the
// sign fix-up helper used when results leave the iterative datapath.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_NOP   = 3'b110
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    localparam int MD_OP_W   = 3;
    // Widest operand the shared negate can serve; product needs 2*WIDTH < 2*MD_MAX_W.
    localparam int MD_MAX_W  = 64;
    localparam logic [2*MD_MAX_W-1:0] MD_ONE = {{(2*MD_MAX_W-1){1'b0}}, 1'b1};

    // Conditional two's-complement negate, zero-extend narrower values into it.
    function automatic logic [2*MD_MAX_W-1:0] md_cneg(input logic neg,
                                                     input logic [2*MD_MAX_W-1:0] val);
        return neg ? (~val + MD_ONE) : val;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS core.
// Magnitudes are iterated unsigned (shift-add / restoring divide); signs are fixed in FIX.
//
//   state | meaning
//   IDLE  | ready for an op; MTHI/MTLO/NOP complete here in one cycle
//   RUN   | WIDTH unsigned iterations on the magnitudes, one per cycle
//   FIX   | sign correction applied, HI/LO written on the leaving edge
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = MD_OP_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

    md_state_t            r_state;
    md_state_t            w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_m;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_iter;
    logic                 w_fix_wr;
    logic                 w_wr_hi;
    logic                 w_wr_lo;

    logic                 w_is_md;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_dif;
    logic [2*WIDTH-1:0]   w_step;

    logic [2*MD_MAX_W-1:0] w_p_in;
    logic [2*MD_MAX_W-1:0] w_q_in;
    logic [2*MD_MAX_W-1:0] w_r_in;
    logic [2*MD_MAX_W-1:0] w_p_ext;
    logic [2*MD_MAX_W-1:0] w_q_ext;
    logic [2*MD_MAX_W-1:0] w_r_ext;
    logic [WIDTH-1:0]      w_res_hi;
    logic [WIDTH-1:0]      w_res_lo;
    logic                  w_unused_bits;

    assign w_is_md     = ~i_op[2];
    assign w_is_div    = i_op[1];
    assign w_is_signed = ~i_op[0];
    assign w_a_neg     = w_is_signed & i_a[WIDTH-1];
    assign w_b_neg     = w_is_signed & i_b[WIDTH-1];
    assign w_b_zero    = (i_b == '0);
    assign w_a_mag     = w_a_neg ? (~i_a + ONE_W) : i_a;
    assign w_b_mag     = w_b_neg ? (~i_b + ONE_W) : i_b;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (i_abort) begin
                    w_next = IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Abort in IDLE blocks the accept so a squashed op never takes effect.
    always_comb begin
        o_busy     = (r_state != IDLE);
        o_op_ready = (r_state == IDLE);
        w_accept   = i_op_valid && (r_state == IDLE) && !i_abort;
        w_start    = w_accept && w_is_md;
        w_wr_hi    = w_accept && (i_op == MD_MTHI);
        w_wr_lo    = w_accept && (i_op == MD_MTLO);
        w_iter     = (r_state == RUN) && !i_abort;
        w_fix_wr   = (r_state == FIX) && !i_abort;
    end

    // One iteration: multiply adds into the upper half and shifts right;
    // divide shifts the partial remainder left and subtracts when it fits.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
        w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_rem_dif = w_rem_sh - {1'b0, r_m};
        if (r_is_div) begin
            if (w_rem_dif[WIDTH]) begin
                w_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end else begin
                w_step = {w_rem_dif[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_p_in = '0;
        w_q_in = '0;
        w_r_in = '0;
        w_p_in[2*WIDTH-1:0] = r_acc;
        w_q_in[WIDTH-1:0]   = r_acc[WIDTH-1:0];
        w_r_in[WIDTH-1:0]   = r_acc[2*WIDTH-1:WIDTH];
        w_p_ext = md_cneg(r_neg_q, w_p_in);
        w_q_ext = md_cneg(r_neg_q, w_q_in);
        w_r_ext = md_cneg(r_neg_r, w_r_in);
        if (r_is_div) begin
            w_res_hi = w_r_ext[WIDTH-1:0];
            w_res_lo = w_q_ext[WIDTH-1:0];
        end else begin
            w_res_hi = w_p_ext[2*WIDTH-1:WIDTH];
            w_res_lo = w_p_ext[WIDTH-1:0];
        end
    end

    assign w_unused_bits = ^{w_p_ext[2*MD_MAX_W-1:2*WIDTH],
                             w_q_ext[2*MD_MAX_W-1:WIDTH],
                             w_r_ext[2*MD_MAX_W-1:WIDTH]};

    // Divide by zero iterates to quotient all-ones and remainder |a|; clearing the
    // quotient sign leaves lo all-ones and the remainder sign restores hi = a.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_m      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fix_wr;
            if (w_start) begin
                r_cnt    <= CNT_W'(WIDTH);
                r_is_div <= w_is_div;
                r_neg_q  <= (w_a_neg ^ w_b_neg) & ~(w_is_div & w_b_zero);
                r_neg_r  <= w_is_div & w_a_neg;
                r_m      <= w_is_div ? w_b_mag : w_a_mag;
                r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            end else if (w_iter) begin
                r_cnt <= r_cnt - CNT_ONE;
                r_acc <= w_step;
            end
            if (w_fix_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_wr_hi) begin
                    r_hi <= i_a;
                end
                if (w_wr_lo) begin
                    r_lo <= i_a;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
